// File: rtl/if_controller.sv
// ============================================================================
// Module   : if_controller
// Brief    : Instruction-fetch stage with RUN/HALT/FAULT control and IF/ID register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_controller #(
  parameter int          SIZE_EXP2 = 10,
  parameter logic [31:0] RESET_PC  = 32'h00000000
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_target,
  input  logic [31:0]          imem_data,
  output logic [SIZE_EXP2-1:0] imem_address,
  output logic [31:0]          pc,
  output logic                 if_valid,
  output logic [31:0]          if_instruction,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_pc_plus4,
  output logic                 halted,
  output logic                 fault
);

  localparam logic [1:0]  c_RUN   = 2'd0;
  localparam logic [1:0]  c_HALT  = 2'd1;
  localparam logic [1:0]  c_FAULT = 2'd2;
  localparam logic [31:0] c_BREAK = 32'h0000000D;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc4;
  logic [31:0] w_pc_plus4;
  logic        w_beyond;

  assign w_pc_plus4 = r_pc + 32'd4;

  // A memory spanning the full 32-bit space has no out-of-range addresses.
  generate
    if (SIZE_EXP2 < 30) begin : g_bound
      assign w_beyond = |r_pc[31:SIZE_EXP2+2];
    end else begin : g_nobound
      assign w_beyond = 1'b0;
    end
  endgenerate

  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_state  <= c_RUN;
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_instr  <= 32'd0;
      r_if_pc  <= 32'd0;
      r_if_pc4 <= 32'd0;
    end else begin
      case (r_state)
        c_RUN: begin
          if (redirect) begin
            r_pc    <= redirect_target;
            r_valid <= 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
              r_state <= c_FAULT;
            end
          end else if (!stall) begin
            if (w_beyond) begin
              r_valid <= 1'b0;
              r_state <= c_FAULT;
            end else begin
              r_instr  <= imem_data;
              r_if_pc  <= r_pc;
              r_if_pc4 <= w_pc_plus4;
              r_valid  <= 1'b1;
              r_pc     <= w_pc_plus4;
              if (imem_data == c_BREAK) begin
                r_state <= c_HALT;
              end
            end
          end
        end
        c_HALT, c_FAULT: begin
          r_valid <= 1'b0;
        end
        default: begin
          // Unreachable encoding is treated as a fault.
          r_valid <= 1'b0;
          r_state <= c_FAULT;
        end
      endcase
    end
  end

  assign imem_address   = r_pc[SIZE_EXP2+1:2];
  assign pc             = r_pc;
  assign if_valid       = r_valid;
  assign if_instruction = r_instr;
  assign if_pc          = r_if_pc;
  assign if_pc_plus4    = r_if_pc4;
  assign halted         = (r_state == c_HALT);
  assign fault          = (r_state == c_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_if_controller.sv
// ============================================================================
// Module   : tb_if_controller
// Brief    : Self-checking bench for if_controller (two memory sizes, random + directed).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] tgt = 32'd0;
  logic [31:0] mem [0:1023];

  logic [9:0]  a10;
  logic [31:0] pc10, ins10, ipc10, ipc4_10;
  logic        v10, h10, f10;
  logic [3:0]  a4;
  logic [31:0] pc4, ins4, ipc4, ipc4_4;
  logic        v4, h4, f4;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  if_controller #(.SIZE_EXP2(10), .RESET_PC(32'h0)) dut10 (
    .system_clock(clk), .reset(rst), .stall(stall), .redirect(redirect),
    .redirect_target(tgt), .imem_data(mem[a10]), .imem_address(a10),
    .pc(pc10), .if_valid(v10), .if_instruction(ins10), .if_pc(ipc10),
    .if_pc_plus4(ipc4_10), .halted(h10), .fault(f10));

  if_controller #(.SIZE_EXP2(4), .RESET_PC(32'h0)) dut4 (
    .system_clock(clk), .reset(rst), .stall(stall), .redirect(redirect),
    .redirect_target(tgt), .imem_data(mem[{6'd0, a4}]), .imem_address(a4),
    .pc(pc4), .if_valid(v4), .if_instruction(ins4), .if_pc(ipc4),
    .if_pc_plus4(ipc4_4), .halted(h4), .fault(f4));

  // Behavioural model: mode 0 = running, 1 = halted, 2 = faulted.
  typedef struct {
    int          mode;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
  } mdl_t;

  mdl_t m10, m4;

  function automatic mdl_t step(mdl_t m, int sz, bit r, bit s, bit d, logic [31:0] t);
    mdl_t n = m;
    logic [31:0] word;
    if (r) begin
      n.mode = 0; n.pc = 0; n.valid = 0; n.instr = 0; n.ipc = 0; n.ipc4 = 0;
    end else if (m.mode != 0) begin
      n.valid = 0;
    end else if (d) begin
      n.pc = t;
      n.valid = 0;
      if (t % 4 != 0) n.mode = 2;
    end else if (!s) begin
      if ((m.pc >> (sz + 2)) != 0) begin
        n.valid = 0;
        n.mode = 2;
      end else begin
        word = mem[(m.pc / 4) % (1 << sz)];
        n.instr = word; n.ipc = m.pc; n.ipc4 = m.pc + 4; n.valid = 1;
        n.pc = m.pc + 4;
        if (word == 32'd13) n.mode = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m10 = step(m10, 10, rst, stall, redirect, tgt);
    m4  = step(m4, 4, rst, stall, redirect, tgt);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d10.pc", pc10, m10.pc);
      chk("d10.addr", {22'd0, a10}, (m10.pc / 4) % 1024);
      chk("d10.valid", {31'd0, v10}, {31'd0, m10.valid});
      chk("d10.instr", ins10, m10.instr);
      chk("d10.if_pc", ipc10, m10.ipc);
      chk("d10.if_pc4", ipc4_10, m10.ipc4);
      chk("d10.halted", {31'd0, h10}, (m10.mode == 1) ? 32'd1 : 32'd0);
      chk("d10.fault", {31'd0, f10}, (m10.mode == 2) ? 32'd1 : 32'd0);
      chk("d4.pc", pc4, m4.pc);
      chk("d4.addr", {28'd0, a4}, (m4.pc / 4) % 16);
      chk("d4.valid", {31'd0, v4}, {31'd0, m4.valid});
      chk("d4.instr", ins4, m4.instr);
      chk("d4.if_pc", ipc4, m4.ipc);
      chk("d4.if_pc4", ipc4_4, m4.ipc4);
      chk("d4.halted", {31'd0, h4}, (m4.mode == 1) ? 32'd1 : 32'd0);
      chk("d4.fault", {31'd0, f4}, (m4.mode == 2) ? 32'd1 : 32'd0);
    end
  end

  task automatic cyc(input bit r, input bit s, input bit d, input logic [31:0] t);
    rst = r; stall = s; redirect = d; tgt = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 32'(i) * 4;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[16] = 32'h55;
  endtask

  initial begin
    int sel;
    fill_mem();
    @(negedge clk);
    cyc(1, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst.pc", pc10, 32'h0);
    chk("rst.valid", {31'd0, v10}, 32'd0);
    chk("rst.instr", ins10, 32'h0);

    // Sequential fetch, then a three-cycle stall holding the IF/ID slot.
    cyc(0, 0, 0, 0);
    chk("seq1.instr", ins10, 32'h11);
    chk("seq1.if_pc", ipc10, 32'h0);
    cyc(0, 0, 0, 0);
    chk("seq2.instr", ins10, 32'h22);
    chk("seq2.if_pc", ipc10, 32'h4);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("stall.pc", pc10, 32'h8);
      chk("stall.if_pc", ipc10, 32'h4);
      chk("stall.instr", ins10, 32'h22);
    end
    cyc(0, 0, 0, 0);
    chk("resume.instr", ins10, 32'h33);
    chk("resume.if_pc4", ipc4_10, 32'hC);

    // Redirect wins over stall.
    cyc(0, 1, 1, 32'h40);
    chk("redir.pc", pc10, 32'h40);
    chk("redir.valid", {31'd0, v10}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("redir2.if_pc", ipc10, 32'h40);
    chk("redir2.valid", {31'd0, v10}, 32'd1);
    chk("redir2.instr", ins10, 32'h55);
    chk("d4.oob.fault", {31'd0, f4}, 32'd1);

    // Fresh sequential run: words 0,1,2 on cycles 1,2,3.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("seq3.instr", ins10, 32'h33);
    chk("seq3.if_pc", ipc10, 32'h8);
    chk("seq3.valid", {31'd0, v10}, 32'd1);

    // BREAK at word 2.
    mem[2] = 32'h0000000D;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("brk.instr", ins10, 32'hD);
    chk("brk.valid", {31'd0, v10}, 32'd1);
    cyc(0, 0, 1, 32'h100);
    chk("halt.halted", {31'd0, h10}, 32'd1);
    chk("halt.valid", {31'd0, v10}, 32'd0);
    chk("halt.pc", pc10, 32'hC);
    cyc(1, 1, 1, 32'h100);
    chk("halt.rst.pc", pc10, 32'h0);
    chk("halt.rst.halted", {31'd0, h10}, 32'd0);
    mem[2] = 32'h33;

    // Unaligned redirect faults; small memory faults at its end.
    cyc(0, 0, 1, 32'h42);
    chk("unal.fault", {31'd0, f10}, 32'd1);
    chk("unal.pc", pc10, 32'h42);
    chk("unal.valid", {31'd0, v10}, 32'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 32'h38);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("d4.end.pc", pc4, 32'h40);
    chk("d4.end.fault", {31'd0, f4}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("d4.oob2.fault", {31'd0, f4}, 32'd1);
    chk("d4.oob2.pc", pc4, 32'h40);
    chk("d4.oob2.valid", {31'd0, v4}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("d4.hold.pc", pc4, 32'h40);

    // Randomized episodes checked every cycle against the model.
    for (int e = 0; e < 30; e++) begin
      fill_mem();
      for (int k = 0; k < 3; k++) mem[$urandom_range(0, 40)] = ($urandom_range(0, 1) != 0) ? 32'hD : 32'h0;
      cyc(1, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom);
      for (int c = 0; c < 25; c++) begin
        sel = int'($urandom_range(0, 9));
        case (sel)
          0: tgt = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
          1: tgt = 32'h0001_0000 + 32'($urandom_range(0, 15)) * 4;
          2, 3, 4: tgt = 32'($urandom_range(0, 15)) * 4;
          default: tgt = 32'($urandom_range(0, 255)) * 4;
        endcase
        cyc($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, tgt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_controller.md
IF_CONTROLLER -- requirements
Module: if_controller

Interface
REQ-001 SHALL have parameter SIZE_EXP2, default 10: log2 of instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000: fetch address loaded on reset.
REQ-003 SHALL have port system_clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold the fetch stage this cycle.
REQ-006 SHALL have port redirect  input  1  branch/jump taken; load redirect_target.
REQ-007 SHALL have port redirect_target  input  32  byte address of the new fetch target.
REQ-008 SHALL have port imem_data  input  32  word read from instruction memory at imem_address.
REQ-009 SHALL have port imem_address  output  SIZE_EXP2  word address to instruction memory.
REQ-010 SHALL have port pc  output  32  current fetch byte address.
REQ-011 SHALL have port if_valid  output  1  IF/ID register holds a live instruction.
REQ-012 SHALL have port if_instruction  output  32  registered instruction word.
REQ-013 SHALL have port if_pc  output  32  byte address of if_instruction.
REQ-014 SHALL have port if_pc_plus4  output  32  if_pc + 4.
REQ-015 SHALL have port halted  output  1  high while in HALT.
REQ-016 SHALL have port fault  output  1  high while in FAULT.

Function
REQ-017 SHALL drive imem_address = pc[SIZE_EXP2+1:2] combinationally; memory read is combinational, so imem_data is consumed the same cycle.
REQ-018 SHALL implement states RUN, HALT and FAULT; halted and fault SHALL be decoded from state.
REQ-019 In RUN, per edge, priority SHALL be: redirect > stall > advance.
REQ-020 Advance: if_instruction<=imem_data, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4 (modulo 2^32); fetch latency of one cycle from pc to if_*.
REQ-021 Redirect (regardless of stall): pc<=redirect_target, if_valid<=0 (squashes the wrong-path slot); if_instruction, if_pc and if_pc_plus4 hold.
REQ-022 Stall without redirect: pc and all if_* outputs SHALL hold.
REQ-023 Redirect with redirect_target[1:0] != 0 SHALL load pc<=redirect_target, clear if_valid and enter FAULT.
REQ-024 Advance attempted with pc[31:SIZE_EXP2+2] != 0 (beyond memory) SHALL NOT latch imem_data; SHALL clear if_valid, hold pc and enter FAULT.
REQ-025 Advance with imem_data == 32'h0000000D (BREAK) SHALL latch it per REQ-020 with if_valid=1, then enter HALT; pc becomes pc+4.
REQ-026 In HALT and FAULT: pc and if_instruction/if_pc/if_pc_plus4 hold, if_valid<=0, stall and redirect ignored; only reset exits.
REQ-027 Zero words (uninitialised memory) SHALL be fetched as ordinary instructions (NOP), not as halt.
REQ-028 pc wrap from 32'hFFFFFFFC to 0 SHALL occur arithmetically but is pre-empted by REQ-024 for SIZE_EXP2 < 30.

Reset
REQ-029 On reset high at an edge, regardless of state or other inputs: state<=RUN, pc<=RESET_PC, if_valid<=0, if_instruction<=0, if_pc<=0, if_pc_plus4<=0; halted=0, fault=0.
REQ-030 Reset asserted mid-stall, mid-redirect, in HALT or in FAULT SHALL have the identical effect; first fetch occurs on the first edge with reset low.

Verification
REQ-031 Reset, memory words 0..3 = 0x11,0x22,0x33,0x44, no stall -> if_instruction 0x11,0x22,0x33 on cycles 1,2,3 with if_pc 0,4,8 and if_valid=1.
REQ-032 Stall held 3 cycles after if_pc=4 -> pc=8, if_pc=4, if_instruction=0x22 unchanged for 3 cycles, then resumes with 0x33.
REQ-033 redirect=1, stall=1, target=0x40 -> next cycle pc=0x40, if_valid=0; following cycle if_pc=0x40, if_valid=1.
REQ-034 Word 2 = 0x0000000D -> cycle 3 if_instruction=0x0D, if_valid=1; thereafter halted=1, if_valid=0, pc=0xC, redirect ignored; reset returns pc=0, halted=0.
REQ-035 Redirect target 0x42 -> fault=1, pc=0x42, if_valid=0; SIZE_EXP2=4 and sequential fetch to pc=0x40 -> fault=1, pc=0x40 held.
